// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and pipeline_ctrl.
// The controller connects through the slave modport; the datapath drives through master.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    RESULT_ALU = 2'd0,
    RESULT_MEM = 2'd1,
    RESULT_PC4 = 2'd2,
    RESULT_CSR = 2'd3
  } result_src_e;
endpackage

interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic [4:0]       rs1D_i;
  logic [4:0]       rs2D_i;
  logic             csr_readD_i;
  logic [4:0]       rdE_i;
  result_src_e      result_srcE_i;
  logic             csr_writeE_i;
  logic             csr_writeM_i;
  logic             branch_takenE_i;
  logic             memM_i;
  logic             lsu_ack_i;
  logic             trap_i;
  logic             stallF_o;
  logic             stallD_o;
  logic             stallE_o;
  logic             stallM_o;
  logic             flushD_o;
  logic             flushE_o;
  logic             flushM_o;
  logic             redirect_o;
  logic             bus_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output rs1D_i, rs2D_i, csr_readD_i, rdE_i, result_srcE_i, csr_writeE_i,
           csr_writeM_i, branch_takenE_i, memM_i, lsu_ack_i, trap_i,
    input  stallF_o, stallD_o, stallE_o, stallM_o, flushD_o, flushE_o,
           flushM_o, redirect_o, bus_err_o, stall_cnt_o
  );

  modport slave (
    input  rs1D_i, rs2D_i, csr_readD_i, rdE_i, result_srcE_i, csr_writeE_i,
           csr_writeM_i, branch_takenE_i, memM_i, lsu_ack_i, trap_i,
    output stallF_o, stallD_o, stallE_o, stallM_o, flushD_o, flushE_o,
           flushM_o, redirect_o, bus_err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use/CSR stalls, branch flushes, LSU wait with
// timeout bus error, one-cycle trap flush/redirect, and a stalled-fetch cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    TRAP_FLUSH
  } state_e;

  localparam logic [15:0] TIMER_LAST = 16'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic run_like;
  logic load_use;
  logic csr_hazard;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m;
  logic redirect, bus_err;

  always_comb begin
    load_use   = (bus.result_srcE_i == RESULT_MEM) && (bus.rdE_i != 5'd0) &&
                 ((bus.rdE_i == bus.rs1D_i) || (bus.rdE_i == bus.rs2D_i));
    csr_hazard = bus.csr_readD_i && (bus.csr_writeE_i || bus.csr_writeM_i);
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    run_like = 1'b0;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    redirect = 1'b0;
    bus_err  = 1'b0;

    unique case (state_q)
      RUN: run_like = 1'b1;
      MEM_WAIT: begin
        // The ack cycle releases the stall and is evaluated exactly like RUN.
        if (bus.lsu_ack_i) begin
          run_like = 1'b1;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          if (timer_q == TIMER_LAST) begin
            bus_err = 1'b1;
            timer_d = '0;
            state_d = TRAP_FLUSH;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end
      TRAP_FLUSH: begin
        flush_d  = 1'b1;
        flush_e  = 1'b1;
        flush_m  = 1'b1;
        redirect = 1'b1;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase

    if (run_like) begin
      if (bus.memM_i && !bus.lsu_ack_i) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        timer_d = '0;
        state_d = MEM_WAIT;
      end else begin
        state_d = bus.trap_i ? TRAP_FLUSH : RUN;
        if (bus.branch_takenE_i) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use || csr_hazard) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
    end

    if (rst_i) begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_m  = 1'b0;
      redirect = 1'b0;
      bus_err  = 1'b0;
    end

    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_f};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      timer_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stallF_o    = stall_f;
  assign bus.stallD_o    = stall_d;
  assign bus.stallE_o    = stall_e;
  assign bus.stallM_o    = stall_m;
  assign bus.flushD_o    = flush_d;
  assign bus.flushE_o    = flush_e;
  assign bus.flushM_o    = flush_m;
  assign bus.redirect_o  = redirect;
  assign bus.bus_err_o   = bus_err;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the controller rules.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 4;

  // Output vector order: stallF stallD stallE stallM flushD flushE flushM redirect bus_err
  localparam logic [8:0] O_IDLE     = 9'b000000000;
  localparam logic [8:0] O_MEMSTALL = 9'b111100000;
  localparam logic [8:0] O_TMO      = 9'b111100001;
  localparam logic [8:0] O_HAZ      = 9'b110001000;
  localparam logic [8:0] O_BR       = 9'b000011000;
  localparam logic [8:0] O_TRAPF    = 9'b000011110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: "waiting" = memory access outstanding, wait_n = MEM_WAIT cycles so far,
  // "flush_next" = trap flush owed next cycle, cnt = stalled fetch cycles mod 2**CW.
  bit          m_wait, m_flush, n_wait, n_flush;
  int unsigned m_wait_n, n_wait_n, m_cnt;
  logic [8:0]  e_out;

  function automatic logic [8:0] observed();
    return {bus.stallF_o, bus.stallD_o, bus.stallE_o, bus.stallM_o,
            bus.flushD_o, bus.flushE_o, bus.flushM_o, bus.redirect_o, bus.bus_err_o};
  endfunction

  task automatic idle_inputs();
    bus.rs1D_i          = 5'd0;
    bus.rs2D_i          = 5'd0;
    bus.csr_readD_i     = 1'b0;
    bus.rdE_i           = 5'd0;
    bus.result_srcE_i   = RESULT_ALU;
    bus.csr_writeE_i    = 1'b0;
    bus.csr_writeM_i    = 1'b0;
    bus.branch_takenE_i = 1'b0;
    bus.memM_i          = 1'b0;
    bus.lsu_ack_i       = 1'b0;
    bus.trap_i          = 1'b0;
  endtask

  task automatic predict();
    bit hazard;
    hazard = (bus.result_srcE_i == RESULT_MEM && bus.rdE_i != 5'd0 &&
              (bus.rdE_i == bus.rs1D_i || bus.rdE_i == bus.rs2D_i)) ||
             (bus.csr_readD_i && (bus.csr_writeE_i || bus.csr_writeM_i));
    e_out    = O_IDLE;
    n_wait   = 1'b0;
    n_flush  = 1'b0;
    n_wait_n = 0;
    if (rst) begin
      m_wait = 1'b0; m_flush = 1'b0; m_wait_n = 0; m_cnt = 0;
      return;
    end
    if (m_flush) begin
      e_out = O_TRAPF;
    end else if (m_wait && !bus.lsu_ack_i) begin
      e_out = O_MEMSTALL;
      if (m_wait_n + 1 == TMO) begin
        e_out   = O_TMO;
        n_flush = 1'b1;
      end else begin
        n_wait   = 1'b1;
        n_wait_n = m_wait_n + 1;
      end
    end else if (bus.memM_i && !bus.lsu_ack_i) begin
      e_out  = O_MEMSTALL;
      n_wait = 1'b1;
    end else begin
      n_flush = bus.trap_i;
      if (bus.branch_takenE_i) e_out = O_BR;
      else if (hazard)         e_out = O_HAZ;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_cnt    = rst ? 0 : (m_cnt + (e_out[8] ? 1 : 0)) % (1 << CW);
    m_wait   = n_wait;
    m_flush  = n_flush;
    m_wait_n = n_wait_n;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1 predict();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      bus.memM_i = 1'b1; bus.trap_i = 1'b1; bus.branch_takenE_i = 1'b1;
      bus.csr_readD_i = 1'b1; bus.csr_writeE_i = 1'b1;
      #1 predict();
      total++;
      if (observed() !== O_IDLE) begin
        bad++; $display("FAIL reset_outputs: got %b want %b", observed(), O_IDLE);
      end
      total++;
      if (bus.stall_cnt_o !== 4'd0) begin
        bad++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt_o);
      end
      advance();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use();
    logic [4:0] rd_t[4]  = '{5'd5, 5'd0, 5'd31, 5'd7};
    logic [4:0] rs1_t[4] = '{5'd5, 5'd0, 5'd2,  5'd7};
    logic [4:0] rs2_t[4] = '{5'd9, 5'd0, 5'd31, 5'd7};
    bit         mem_t[4] = '{1'b1, 1'b1, 1'b1,  1'b0};
    logic [8:0] exp_t[4] = '{O_HAZ, O_IDLE, O_HAZ, O_IDLE};
    bus.result_srcE_i = RESULT_MEM; bus.rdE_i = 5'd5; bus.rs1D_i = 5'd5;
    #1 predict();
    total++;
    if (observed() !== O_HAZ) begin
      bad++; $display("FAIL load_use: got %b want %b", observed(), O_HAZ);
    end
    total++;
    if (bus.stall_cnt_o !== 4'd0) begin
      bad++; $display("FAIL load_use_cnt0: got %0d want 0", bus.stall_cnt_o);
    end
    advance();
    idle_inputs();
    #1 predict();
    total++;
    if (observed() !== O_IDLE) begin
      bad++; $display("FAIL load_use_release: got %b want %b", observed(), O_IDLE);
    end
    total++;
    if (bus.stall_cnt_o !== 4'd1) begin
      bad++; $display("FAIL load_use_cnt1: got %0d want 1", bus.stall_cnt_o);
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      bus.result_srcE_i = mem_t[i] ? RESULT_MEM : RESULT_ALU;
      bus.rdE_i = rd_t[i]; bus.rs1D_i = rs1_t[i]; bus.rs2D_i = rs2_t[i];
      #1 predict();
      total++;
      if (observed() !== exp_t[i]) begin
        bad++; $display("FAIL load_use_case%0d: got %b want %b", i, observed(), exp_t[i]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_lsu_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.memM_i = 1'b1; bus.lsu_ack_i = 1'b0;
      #1 predict();
      total++;
      if (observed() !== O_MEMSTALL) begin
        bad++; $display("FAIL lsu_wait_c%0d: got %b want %b", i, observed(), O_MEMSTALL);
      end
      advance();
    end
    bus.lsu_ack_i = 1'b1;
    #1 predict();
    total++;
    if (observed() !== O_IDLE) begin
      bad++; $display("FAIL lsu_ack: got %b want %b", observed(), O_IDLE);
    end
    total++;
    if (bus.stall_cnt_o !== 4'd3) begin
      bad++; $display("FAIL lsu_cnt: got %0d want 3", bus.stall_cnt_o);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic [8:0] want;
    bus.memM_i = 1'b1; bus.lsu_ack_i = 1'b0;
    for (int i = 0; i <= int'(TMO); i++) begin
      want = (i == int'(TMO)) ? O_TMO : O_MEMSTALL;
      #1 predict();
      total++;
      if (observed() !== want) begin
        bad++; $display("FAIL timeout_c%0d: got %b want %b", i, observed(), want);
      end
      advance();
    end
    #1 predict();
    total++;
    if (observed() !== O_TRAPF) begin
      bad++; $display("FAIL timeout_flush: got %b want %b", observed(), O_TRAPF);
    end
    advance();
    idle_inputs();
    #1 predict();
    total++;
    if (observed() !== O_IDLE) begin
      bad++; $display("FAIL timeout_run: got %b want %b", observed(), O_IDLE);
    end
    advance();
  endtask

  task automatic test_branch_hazard();
    bit         rd_t[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit         we_t[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit         wm_t[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit         br_t[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [8:0] ex_t[5] = '{O_BR, O_HAZ, O_IDLE, O_IDLE, O_BR};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      bus.csr_readD_i = rd_t[i]; bus.csr_writeE_i = we_t[i];
      bus.csr_writeM_i = wm_t[i]; bus.branch_takenE_i = br_t[i];
      if (i == 4) begin
        bus.result_srcE_i = RESULT_MEM; bus.rdE_i = 5'd3; bus.rs2D_i = 5'd3;
      end
      #1 predict();
      total++;
      if (observed() !== ex_t[i]) begin
        bad++; $display("FAIL branch_case%0d: got %b want %b", i, observed(), ex_t[i]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_trap();
    bit         tr_t[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit         mm_t[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit         ak_t[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0] ex_t[8] = '{O_IDLE, O_TRAPF, O_IDLE, O_MEMSTALL, O_MEMSTALL,
                            O_IDLE, O_TRAPF, O_IDLE};
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      bus.trap_i = tr_t[i]; bus.memM_i = mm_t[i]; bus.lsu_ack_i = ak_t[i];
      #1 predict();
      total++;
      if (observed() !== ex_t[i]) begin
        bad++; $display("FAIL trap_step%0d: got %b want %b", i, observed(), ex_t[i]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.csr_readD_i = 1'b1; bus.csr_writeM_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1 predict();
      total++;
      if (observed() !== O_HAZ) begin
        bad++; $display("FAIL wrap_stall%0d: got %b want %b", i, observed(), O_HAZ);
      end
      advance();
    end
    idle_inputs();
    #1 predict();
    total++;
    if (bus.stall_cnt_o !== 4'd1) begin
      bad++; $display("FAIL wrap_cnt: got %0d want 1", bus.stall_cnt_o);
    end
    advance();
  endtask

  task automatic test_reset_mid_wait();
    bus.memM_i = 1'b1; bus.lsu_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 predict();
      total++;
      if (observed() !== O_MEMSTALL) begin
        bad++; $display("FAIL rstwait_stall%0d: got %b want %b", i, observed(), O_MEMSTALL);
      end
      advance();
    end
    // Reset pulse lies entirely between clock edges.
    #1 rst = 1'b1;
    #1;
    total++;
    if (observed() !== O_IDLE) begin
      bad++; $display("FAIL rstwait_in_reset: got %b want %b", observed(), O_IDLE);
    end
    total++;
    if (bus.stall_cnt_o !== 4'd0) begin
      bad++; $display("FAIL rstwait_cnt: got %0d want 0", bus.stall_cnt_o);
    end
    idle_inputs();
    #1 rst = 1'b0;
    m_wait = 1'b0; m_flush = 1'b0; m_wait_n = 0; m_cnt = 0;
    #1 predict();
    total++;
    if (observed() !== O_IDLE) begin
      bad++; $display("FAIL rstwait_released: got %b want %b", observed(), O_IDLE);
    end
    advance();
    for (int i = 0; i < int'(TMO) + 2; i++) begin
      #1 predict();
      total++;
      if (observed() !== O_IDLE) begin
        bad++; $display("FAIL rstwait_quiet%0d: got %b want %b", i, observed(), O_IDLE);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst                 = ($urandom_range(0, 63) == 0);
      bus.rs1D_i          = 5'($urandom_range(0, 3));
      bus.rs2D_i          = 5'($urandom_range(0, 3));
      bus.rdE_i           = 5'($urandom_range(0, 3));
      bus.result_srcE_i   = result_src_e'(2'($urandom_range(0, 3)));
      bus.csr_readD_i     = ($urandom_range(0, 3) == 0);
      bus.csr_writeE_i    = ($urandom_range(0, 2) == 0);
      bus.csr_writeM_i    = ($urandom_range(0, 2) == 0);
      bus.branch_takenE_i = ($urandom_range(0, 3) == 0);
      bus.memM_i          = ($urandom_range(0, 3) == 0);
      bus.lsu_ack_i       = ($urandom_range(0, 2) == 0);
      bus.trap_i          = ($urandom_range(0, 15) == 0);
      #1 predict();
      total++;
      if (observed() !== e_out) begin
        bad++; $display("FAIL random_out%0d: got %b want %b", i, observed(), e_out);
      end
      total++;
      if (bus.stall_cnt_o !== 4'(m_cnt)) begin
        bad++; $display("FAIL random_cnt%0d: got %0d want %0d", i, bus.stall_cnt_o, m_cnt);
      end
      advance();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_wait = 1'b0; m_flush = 1'b0; m_wait_n = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_lsu_wait();
    test_timeout();
    test_branch_hazard();
    test_trap();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, SHALL set the maximum MEM_WAIT cycles before a bus error; legal range 2..65535.
REQ-002 Parameter CNT_W, default 32, SHALL set the stall-cycle counter width; legal range 4..64.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be:
 clk_i  in  1  clock, rising edge
 rst_i  in  1  asynchronous reset, active-high
 rs1D_i  in  5  decode source register 1
 rs2D_i  in  5  decode source register 2
 csr_readD_i  in  1  decode instruction reads a CSR
 rdE_i  in  5  execute destination register
 result_srcE_i  in  result_src_e  execute result source; RESULT_MEM marks a load
 csr_writeE_i  in  1  CSR write in execute
 csr_writeM_i  in  1  CSR write in memory
 branch_takenE_i  in  1  taken branch or jump resolved in execute
 memM_i  in  1  load or store occupying memory stage
 lsu_ack_i  in  1  LSU completes the memory-stage access this cycle
 trap_i  in  1  exception raised by the memory-stage instruction
 stallF_o, stallD_o, stallE_o, stallM_o  out  1 each  hold the stage register
 flushD_o, flushE_o, flushM_o  out  1 each  load NOP into the stage register
 redirect_o  out  1  fetch selects the trap vector this cycle
 bus_err_o  out  1  one-cycle pulse on LSU timeout
 stall_cnt_o  out  CNT_W  count of cycles with stallF_o=1

Function
REQ-005 The FSM SHALL have three states: RUN, MEM_WAIT and TRAP_FLUSH.
REQ-006 RUN with memM_i=1 and lsu_ack_i=0 SHALL assert all four stalls in the same cycle, clear the wait timer and go to MEM_WAIT.
REQ-007 In MEM_WAIT, while lsu_ack_i=0, all four stalls SHALL be 1 and all flushes 0; the wait timer SHALL increment each cycle.
REQ-008 MEM_WAIT with lsu_ack_i=1 SHALL deassert the MEM_WAIT-driven stalls in that same cycle and go to RUN; trap_i in that cycle SHALL be handled as in RUN.
REQ-009 In MEM_WAIT, when the timer equals MEM_TIMEOUT-1 with lsu_ack_i=0, bus_err_o SHALL pulse for exactly that cycle and the next state SHALL be TRAP_FLUSH.
REQ-010 When trap_i=1 in RUN and no memory wait starts, the next state SHALL be TRAP_FLUSH; trap_i SHALL be ignored while the MEM_WAIT stall is active.
REQ-011 TRAP_FLUSH SHALL last exactly one cycle, with flushD_o=flushE_o=flushM_o=1, redirect_o=1 and all stalls 0, and SHALL then go to RUN.
REQ-012 Load-use hazard in RUN SHALL mean result_srcE_i==RESULT_MEM, rdE_i!=0, and rdE_i==rs1D_i or rdE_i==rs2D_i; it SHALL assert stallF_o, stallD_o and flushE_o for that cycle.
REQ-013 CSR hazard in RUN SHALL mean csr_readD_i and (csr_writeE_i or csr_writeM_i); it SHALL assert stallF_o, stallD_o and flushE_o for that cycle.
REQ-014 branch_takenE_i in RUN SHALL assert flushD_o and flushE_o and SHALL override load-use and CSR stalls of stallF_o and stallD_o.
REQ-015 Priority SHALL be, highest first: reset > MEM_WAIT stall > TRAP_FLUSH > branch flush > load-use or CSR hazard.
REQ-016 Under a MEM_WAIT stall, flushE_o SHALL be 0 (no bubble) and the hazard outputs SHALL be suppressed.
REQ-017 stall_cnt_o SHALL increment by 1 on each clock with stallF_o=1 and SHALL wrap from all-ones to 0.
REQ-018 All outputs other than stall_cnt_o SHALL be combinational from state and inputs; the state, timer and counter SHALL be registers.

Reset
REQ-019 rst_i=1 SHALL asynchronously force state RUN, timer 0 and stall_cnt_o 0; while in reset, every stall, flush, redirect_o and bus_err_o SHALL be 0.
REQ-020 rst_i asserted during MEM_WAIT or TRAP_FLUSH SHALL abort the operation with no bus_err_o or redirect_o pulse; the first cycle after reset release SHALL be RUN.

Verification
REQ-021 Load-use: result_srcE_i=RESULT_MEM, rdE_i=5, rs1D_i=5 for one cycle -> stallF_o, stallD_o and flushE_o are 1 for that one cycle and stall_cnt_o goes 0 to 1.
REQ-022 LSU wait: memM_i=1 with lsu_ack_i low for 3 cycles, then high -> all stalls are 1 for 3 cycles and are 0 in the ack cycle; stall_cnt_o=3.
REQ-023 Timeout with MEM_TIMEOUT=4 and lsu_ack_i held 0 -> bus_err_o pulses on the 4th wait cycle, the next cycle is TRAP_FLUSH (three flushes and redirect_o all 1), then RUN.
REQ-024 Branch with hazard: branch_takenE_i=1 together with a CSR hazard -> flushD_o=flushE_o=1 and stallF_o=stallD_o=0.
REQ-025 Wrap and reset: with CNT_W=4, 17 stall cycles -> stall_cnt_o=1; rst_i pulsed mid-MEM_WAIT -> all outputs 0 and no bus_err_o.
